mem_bus_arbiter: RTL and testbench

- Two-master arbiter for the shared valid/ready/wstrb memory bus used by the picorv32 core and the chip-select decode.
- Master 0 is the CPU. Master 1 is a second requester, e.g. a UART boot loader or DMA engine.
- Grants one master at a time, with round-robin fairness, and holds the grant until the transaction completes.
- A bus watchdog aborts transactions whose slave never asserts ready and returns an error word to the master.

---
 rtl/mem_bus_arbiter.sv | 100 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master valid/ready bus arbiter with a watchdog that aborts hung transactions
module mem_bus_arbiter #(
  parameter int TIMEOUT = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout,
  output logic [7:0]  timeout_count
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic own, busy, abrt;
  assign own  = grant_q[1];
  assign busy = state_q == BUSY;
  assign abrt = state_q == ABORT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: if (m0_valid || m1_valid) begin
        state_d = BUSY;
        grant_d = (m1_valid && (!m0_valid || !last_q)) ? 2'b10 : 2'b01;
        cnt_d   = '0;
      end
      BUSY: if (s_ready) begin
        state_d = IDLE;
        grant_d = 2'b00;
        last_d  = own;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = ABORT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = 2'b00;
        last_d  = own;
        tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end
  assign s_valid       = busy && (own ? m1_valid : m0_valid);
  assign s_addr        = busy ? (own ? m1_addr : m0_addr) : '0;
  assign s_wdata       = busy ? (own ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb       = busy ? (own ? m1_wstrb : m0_wstrb) : '0;
  assign m0_ready      = grant_q[0] && (busy ? s_ready : abrt);
  assign m1_ready      = grant_q[1] && (busy ? s_ready : abrt);
  assign m0_rdata      = !grant_q[0] ? '0 : busy ? s_rdata : abrt ? ERR_DATA : '0;
  assign m1_rdata      = !grant_q[1] ? '0 : busy ? s_rdata : abrt ? ERR_DATA : '0;
  assign grant         = grant_q;
  assign timeout       = abrt;
  assign timeout_count = tcnt_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench; stimulus queues expected completions and grants, a monitor pops and compares them
module tb_mem_bus_arbiter;
  logic clk = 0, rst = 1;
  logic m0_valid = 0, m1_valid = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic m0_ready, m1_ready, s_valid, s_ready, timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic [1:0] grant;
  logic [7:0] timeout_count;
  int checks = 0, errors = 0;
  int slv_mode = 0;
  logic rdy_q = 0;
  logic [32:0] q0[$], q1[$];
  logic [1:0] gq[$];
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  mem_bus_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout(timeout), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // slave: mode 0 combinational ready, 1 registered ready (lingers one cycle), 2 never ready
  always @(posedge clk) rdy_q <= rst ? 1'b0 : s_valid;
  assign s_ready = slv_mode == 0 ? s_valid : slv_mode == 1 ? rdy_q : 1'b0;
  assign s_rdata = (s_addr == 32'h1004) ? 32'h1234_5678 : ~s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [1:0] pg;
    logic [32:0] e;
    pg = 2'b00;
    forever begin
      @(negedge clk);
      if (m0_ready && m1_ready) chk("both_ready", 32'(m1_ready), 32'd0);
      if (m0_ready) begin
        if (q0.size() == 0) chk("m0_spurious_ready", 32'(m0_ready), 32'd0);
        else begin
          e = q0.pop_front();
          chk("m0_rdata", m0_rdata, e[31:0]);
          chk("m0_timeout", 32'(timeout), 32'(e[32]));
        end
      end
      if (m1_ready) begin
        if (q1.size() == 0) chk("m1_spurious_ready", 32'(m1_ready), 32'd0);
        else begin
          e = q1.pop_front();
          chk("m1_rdata", m1_rdata, e[31:0]);
          chk("m1_timeout", 32'(timeout), 32'(e[32]));
        end
      end
      if (grant != 2'b00 && pg == 2'b00) begin
        if (gq.size() == 0) chk("unexpected_grant", 32'(grant), 32'd0);
        else chk("grant", 32'(grant), 32'(gq.pop_front()));
      end
      pg = grant;
    end
  end

  task automatic xact(input int m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                      input logic [31:0] er, input logic eto);
    if (m == 0) begin
      q0.push_back({eto, er});
      m0_addr = a; m0_wdata = w; m0_wstrb = s; m0_valid = 1;
    end else begin
      q1.push_back({eto, er});
      m1_addr = a; m1_wdata = w; m1_wstrb = s; m1_valid = 1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m == 0 ? m0_ready : m1_ready) begin
        @(posedge clk); #1;
        if (m == 0) m0_valid = 0; else m1_valid = 0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL m%0d_wait no ready within 40 cycles got 0 expected 1", m);
  endtask

  task automatic do_rst();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached got running expected finished");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_m_ready", 32'({m0_ready, m1_ready}), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_tcount", 32'(timeout_count), 32'd0);
    @(posedge clk); #1 rst = 0;

    // single master read, registered-ready slave
    slv_mode = 1;
    q0.push_back({1'b0, 32'h1234_5678});
    gq.push_back(2'b01);
    m0_addr = 32'h1004; m0_wstrb = 0; m0_valid = 1;
    @(negedge clk);
    chk("t1_idle_s_valid", 32'(s_valid), 32'd0);
    @(negedge clk);
    chk("t1_grant_n1", 32'(grant), 32'd1);
    chk("t1_s_valid_n1", 32'(s_valid), 32'd1);
    chk("t1_s_addr_n1", s_addr, 32'h1004);
    chk("t1_m0_ready_n1", 32'(m0_ready), 32'd0);
    @(negedge clk);
    chk("t1_m0_ready_n2", 32'(m0_ready), 32'd1);
    chk("t1_m1_ready_n2", 32'(m1_ready), 32'd0);
    @(posedge clk); #1 m0_valid = 0;

    // simultaneous requests from reset, then strict alternation
    do_rst();
    slv_mode = 0;
    for (int k = 0; k < 2; k++) begin
      gq.push_back(2'b01); gq.push_back(2'b10);
      fork
        xact(0, 32'h100 + 32'(k), 0, 0, ~(32'h100 + 32'(k)), 0);
        xact(1, 32'h200 + 32'(k), 0, 0, ~(32'h200 + 32'(k)), 0);
      join
    end

    // contention hold-off: m1 write waits while m0 owns the bus
    slv_mode = 1;
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      xact(0, 32'h2000, 0, 0, ~32'h2000, 0);
      begin
        @(posedge clk); #1;
        xact(1, 32'h3000, 32'hA5, 4'b0001, ~32'h3000, 0);
      end
      begin : watch
        bit seen_w;
        seen_w = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (grant == 2'b01) chk("t3_wstrb_held", 32'(s_wstrb), 32'd0);
          if (grant == 2'b10 && s_valid && !seen_w) begin
            seen_w = 1;
            chk("t3_w_addr", s_addr, 32'h3000);
            chk("t3_w_data", s_wdata, 32'hA5);
            chk("t3_w_strb", 32'(s_wstrb), 32'b0001);
          end
        end
        chk("t3_write_seen", 32'(seen_w), 32'd1);
      end
    join

    // stale registered ready lingering into IDLE
    gq.push_back(2'b01); gq.push_back(2'b01);
    xact(0, 32'h7000, 0, 0, ~32'h7000, 0);
    @(negedge clk);
    chk("t5_stale_no_ready", 32'({m0_ready, m1_ready}), 32'd0);
    xact(0, 32'h7004, 0, 0, ~32'h7004, 0);

    // watchdog abort with TIMEOUT=4
    slv_mode = 2;
    gq.push_back(2'b01);
    fork
      xact(0, 32'h4000, 0, 0, ERR, 1);
      begin : wd
        int n;
        bit seen;
        n = 0; seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
          @(negedge clk);
          if (timeout) begin
            seen = 1;
            chk("t4_abort_s_valid", 32'(s_valid), 32'd0);
            chk("t4_abort_s_wstrb", 32'(s_wstrb), 32'd0);
          end else if (s_valid) n++;
        end
        chk("t4_abort_seen", 32'(seen), 32'd1);
        chk("t4_busy_cycles", 32'(n), 32'd4);
      end
    join
    @(negedge clk);
    chk("t4_pulse_one_cycle", 32'(timeout), 32'd0);
    chk("t4_tcount_1", 32'(timeout_count), 32'd1);
    for (int k = 1; k < 300; k++) begin
      gq.push_back(2'b01);
      xact(0, 32'h4000, 0, 0, ERR, 1);
    end
    @(negedge clk);
    chk("t4_tcount_sat", 32'(timeout_count), 32'd255);

    // reset during a pending m1 transaction
    gq.push_back(2'b10);
    m1_addr = 32'h5000; m1_wdata = 0; m1_wstrb = 0; m1_valid = 1;
    repeat (2) @(negedge clk);
    chk("t6_pre_grant", 32'(grant), 32'd2);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    slv_mode = 0;
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      begin
        @(negedge clk);
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_s_valid", 32'(s_valid), 32'd0);
        chk("t6_tcount", 32'(timeout_count), 32'd0);
        chk("t6_m1_ready", 32'(m1_ready), 32'd0);
      end
      xact(0, 32'h6000, 0, 0, ~32'h6000, 0);
      xact(1, 32'h5000, 0, 0, ~32'h5000, 0);
    join

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("gq_drained", 32'(gq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
